// File: rtl/vga_frame_ctrl_pkg.sv
// rtl/vga_frame_ctrl_pkg.sv - shared constants, config register type and write helper
package vga_frame_ctrl_pkg;

  // Display geometry defaults, shared with vga_sync
  localparam int unsigned DEF_H_DISP = 640;
  localparam int unsigned DEF_V_DISP = 480;
  localparam int unsigned DEF_SPR_W  = 32;
  localparam int unsigned DEF_SPR_H  = 32;
  localparam int unsigned DEF_BORDER = 8;

  localparam logic [2:0] CFG_BG        = 3'd0;
  localparam logic [2:0] CFG_BORDER    = 3'd1;
  localparam logic [2:0] CFG_SPR_COLOR = 3'd2;
  localparam logic [2:0] CFG_SPR_X     = 3'd3;
  localparam logic [2:0] CFG_SPR_Y     = 3'd4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [11:0] RST_BG        = 12'h000;
  localparam logic [11:0] RST_BORDER    = 12'hFFF;
  localparam logic [11:0] RST_SPR_COLOR = 12'hF00;

  typedef struct packed {
    logic [11:0] bg;
    logic [11:0] border;
    logic [11:0] spr_color;
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;
  } cfg_regs_t;

  localparam cfg_regs_t CFG_RESET = '{
    bg:        RST_BG,
    border:    RST_BORDER,
    spr_color: RST_SPR_COLOR,
    spr_x:     10'd0,
    spr_y:     10'd0
  };

  // Addresses 5..7 leave the register set untouched.
  function automatic cfg_regs_t cfg_write(input cfg_regs_t regs,
                                          input logic [2:0] addr,
                                          input logic [11:0] data);
    cfg_regs_t upd;
    upd = regs;
    case (addr)
      CFG_BG:        upd.bg        = data;
      CFG_BORDER:    upd.border    = data;
      CFG_SPR_COLOR: upd.spr_color = data;
      CFG_SPR_X:     upd.spr_x     = data[9:0];
      CFG_SPR_Y:     upd.spr_y     = data[9:0];
      default:       upd           = regs;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/vga_frame_ctrl_if.sv
// rtl/vga_frame_ctrl_if.sv - config write/commit bus between config writer and vga_frame_ctrl
interface vga_frame_ctrl_if;

  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_ready;
  logic        commit_done;

  modport master (
    output cfg_wr,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    input  cfg_ready,
    input  commit_done
  );

  modport slave (
    input  cfg_wr,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    output cfg_ready,
    output commit_done
  );

endinterface

// File: rtl/vga_pix_mux.sv
// rtl/vga_pix_mux.sv - combinational sprite/border/background hit tests and priority select
module vga_pix_mux
  import vga_frame_ctrl_pkg::*;
#(
  parameter int unsigned H_DISP = DEF_H_DISP,
  parameter int unsigned V_DISP = DEF_V_DISP,
  parameter int unsigned SPR_W  = DEF_SPR_W,
  parameter int unsigned SPR_H  = DEF_SPR_H,
  parameter int unsigned BORDER = DEF_BORDER
) (
  input  cfg_regs_t   act,
  input  logic        v_ON,
  input  logic [9:0]  p_x,
  input  logic [9:0]  p_y,
  output logic [11:0] rgb
);

  localparam logic [10:0] SPR_W11  = 11'(SPR_W);
  localparam logic [10:0] SPR_H11  = 11'(SPR_H);
  localparam logic [9:0]  BRD_LO   = 10'(BORDER);
  localparam logic [9:0]  BRD_X_HI = 10'(H_DISP - BORDER);
  localparam logic [9:0]  BRD_Y_HI = 10'(V_DISP - BORDER);

  logic [10:0] x11;
  logic [10:0] y11;
  logic [10:0] sx_lo;
  logic [10:0] sx_hi;
  logic [10:0] sy_lo;
  logic [10:0] sy_hi;
  logic        spr_hit;
  logic        border_hit;

  // 11-bit bounds so a sprite near column 1023 clips instead of wrapping to 0
  assign x11   = {1'b0, p_x};
  assign y11   = {1'b0, p_y};
  assign sx_lo = {1'b0, act.spr_x};
  assign sy_lo = {1'b0, act.spr_y};
  assign sx_hi = sx_lo + SPR_W11;
  assign sy_hi = sy_lo + SPR_H11;

  assign spr_hit = (x11 >= sx_lo) && (x11 < sx_hi) &&
                   (y11 >= sy_lo) && (y11 < sy_hi);

  assign border_hit = (p_x < BRD_LO) || (p_x >= BRD_X_HI) ||
                      (p_y < BRD_LO) || (p_y >= BRD_Y_HI);

  always_comb begin
    rgb = act.bg;
    if (!v_ON) begin
      rgb = 12'h000;
    end else if (spr_hit) begin
      rgb = act.spr_color;
    end else if (border_hit) begin
      rgb = act.border;
    end
  end

endmodule

// File: rtl/vga_frame_ctrl.sv
// rtl/vga_frame_ctrl.sv - shadow/active display config with vblank-synchronous commit and pixel output
module vga_frame_ctrl
  import vga_frame_ctrl_pkg::*;
#(
  parameter int unsigned H_DISP = DEF_H_DISP,
  parameter int unsigned V_DISP = DEF_V_DISP,
  parameter int unsigned SPR_W  = DEF_SPR_W,
  parameter int unsigned SPR_H  = DEF_SPR_H,
  parameter int unsigned BORDER = DEF_BORDER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             utick,
  input  logic             v_ON,
  input  logic [9:0]       p_x,
  input  logic [9:0]       p_y,
  vga_frame_ctrl_if.slave  cfg,
  output logic [11:0]      rgb_pix,
  output logic [15:0]      frame_cnt
);

  localparam logic [9:0] VBLANK_ROW = 10'(V_DISP);

  logic [0:0]  state;
  cfg_regs_t   shadow;
  cfg_regs_t   active;
  logic        vblank_start;
  logic [11:0] mux_rgb;

  assign vblank_start  = utick && (p_y == VBLANK_ROW) && (p_x == 10'd0);
  assign cfg.cfg_ready = (state == ST_IDLE);

  vga_pix_mux #(
    .H_DISP (H_DISP),
    .V_DISP (V_DISP),
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .BORDER (BORDER)
  ) u_pix_mux (
    .act  (active),
    .v_ON (v_ON),
    .p_x  (p_x),
    .p_y  (p_y),
    .rgb  (mux_rgb)
  );

  // A commit requested on the vblank_start cycle itself only reaches PEND,
  // so the copy happens at the following vblank_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      shadow          <= CFG_RESET;
      active          <= CFG_RESET;
      cfg.commit_done <= 1'b0;
      rgb_pix         <= 12'h000;
      frame_cnt       <= 16'd0;
    end else begin
      cfg.commit_done <= 1'b0;
      if (vblank_start) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (utick) begin
        rgb_pix <= mux_rgb;
      end
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_wr) begin
            shadow <= cfg_write(shadow, cfg.cfg_addr, cfg.cfg_data);
          end
          if (cfg.cfg_commit) begin
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (vblank_start) begin
            active          <= shadow;
            cfg.commit_done <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
